// File: rtl/ysyx_24100012_mem_arbiter.sv
// Shares one data-memory port between IFU (read-only) and LSU (read/write),
// one transaction at a time with round-robin priority on ties.
module ysyx_24100012_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    output logic [DW-1:0]   ifu_rdata,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    output logic [DW-1:0]   lsu_rdata,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {M_IFU, M_LSU} master_t;

    state_t          state;
    master_t         owner;
    master_t         last_grant;
    logic [AW-1:0]   addr_q;
    logic            wen_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wmask_q;

    logic idle;
    logic grant_ifu;
    logic grant_lsu;

    // Gated by rst so a held reset keeps req_ready low.
    assign idle = rst && (state == IDLE);

    // On a tie the master that did not win last time goes first.
    assign grant_lsu = idle && lsu_req_valid &&
                       (!ifu_req_valid || last_grant == M_IFU);
    assign grant_ifu = idle && ifu_req_valid && !grant_lsu;

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    assign mem_req_valid = (state == REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign ifu_resp_valid = (state == RESP) && (owner == M_IFU) &&
                            mem_resp_valid;
    assign lsu_resp_valid = (state == RESP) && (owner == M_LSU) &&
                            mem_resp_valid;
    assign ifu_rdata = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata = lsu_resp_valid ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= M_IFU;
            last_grant <= M_IFU;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_ifu) begin
                        addr_q  <= ifu_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        owner   <= M_IFU;
                        state   <= REQ;
                    end else if (grant_lsu) begin
                        addr_q  <= lsu_addr;
                        wen_q   <= lsu_wen;
                        wdata_q <= lsu_wdata;
                        wmask_q <= lsu_wmask;
                        owner   <= M_LSU;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
